// File: rtl/fetch_queue.sv
// Dual-lane instruction FIFO between fetch and decode: up to two pushes and two pops per cycle,
// with the two oldest entries presented combinationally and a redirect flush that empties it.
module fetch_queue #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       push_valid_F,
  input  logic [WIDTH-1:0] pc_F      [1:0],
  input  logic [WIDTH-1:0] instr_F   [1:0],
  input  logic [WIDTH-1:0] normal_F  [1:0],
  output logic             push_ready,
  input  logic [1:0]       pop_count,
  output logic [1:0]       valid_De,
  output logic [WIDTH-1:0] pc_De     [1:0],
  output logic [WIDTH-1:0] instr_De  [1:0],
  output logic [WIDTH-1:0] normal_De [1:0],
  output logic [PTR_W:0]   count,
  output logic             overflow_err
);

  logic [WIDTH-1:0] r_pc     [DEPTH];
  logic [WIDTH-1:0] r_instr  [DEPTH];
  logic [WIDTH-1:0] r_normal [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic [PTR_W-1:0] w_head1;
  logic [PTR_W-1:0] w_tail1;
  logic             w_push_ready;
  logic             w_push_any;
  logic             w_accept;
  logic             w_drop;
  logic [PTR_W:0]   w_push_num;
  logic [PTR_W:0]   w_push_acc;
  logic [PTR_W:0]   w_pop_req;
  logic [PTR_W:0]   w_pop_eff;
  logic [WIDTH-1:0] w_wr0_pc;
  logic [WIDTH-1:0] w_wr0_instr;
  logic [WIDTH-1:0] w_wr0_normal;

  // Readiness looks only at the registered count; a same-cycle pop never frees room for a push.
  assign w_push_ready = (r_count <= (PTR_W+1)'(DEPTH - 2));
  assign w_push_any   = |push_valid_F;
  assign w_accept     = w_push_any & w_push_ready & ~flush;
  assign w_drop       = w_push_any & ~w_push_ready & ~flush;
  assign w_push_num   = (PTR_W+1)'(push_valid_F[0]) + (PTR_W+1)'(push_valid_F[1]);
  assign w_push_acc   = w_accept ? w_push_num : '0;
  assign w_head1      = r_head + PTR_W'(1);
  assign w_tail1      = r_tail + PTR_W'(1);

  always_comb begin
    w_pop_req = '0;
    case (pop_count)
      2'd0:    w_pop_req = '0;
      2'd1:    w_pop_req = (PTR_W+1)'(1);
      default: w_pop_req = (PTR_W+1)'(2);
    endcase
  end

  assign w_pop_eff = (w_pop_req > r_count) ? r_count : w_pop_req;

  // Compaction: the first valid lane always lands at tail, lane1 follows only on a dual push.
  assign w_wr0_pc     = push_valid_F[0] ? pc_F[0]     : pc_F[1];
  assign w_wr0_instr  = push_valid_F[0] ? instr_F[0]  : instr_F[1];
  assign w_wr0_normal = push_valid_F[0] ? normal_F[0] : normal_F[1];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pc[r_tail]     <= w_wr0_pc;
      r_instr[r_tail]  <= w_wr0_instr;
      r_normal[r_tail] <= w_wr0_normal;
      if (&push_valid_F) begin
        r_pc[w_tail1]     <= pc_F[1];
        r_instr[w_tail1]  <= instr_F[1];
        r_normal[w_tail1] <= normal_F[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_pop_eff[PTR_W-1:0];
      r_tail  <= r_tail + w_push_acc[PTR_W-1:0];
      r_count <= r_count + w_push_acc - w_pop_eff;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Lanes beyond the current occupancy are forced to zero so stale storage never leaks out.
  always_comb begin
    valid_De[0]  = (r_count != '0);
    valid_De[1]  = (r_count >= (PTR_W+1)'(2));
    pc_De[0]     = '0;
    instr_De[0]  = '0;
    normal_De[0] = '0;
    pc_De[1]     = '0;
    instr_De[1]  = '0;
    normal_De[1] = '0;
    if (valid_De[0]) begin
      pc_De[0]     = r_pc[r_head];
      instr_De[0]  = r_instr[r_head];
      normal_De[0] = r_normal[r_head];
    end
    if (valid_De[1]) begin
      pc_De[1]     = r_pc[w_head1];
      instr_De[1]  = r_instr[w_head1];
      normal_De[1] = r_normal[w_head1];
    end
  end

  assign push_ready   = w_push_ready;
  assign count        = r_count;
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner sequences, then random traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  push_valid_F = 2'b00;
  logic [1:0]  pop_count = 2'b00;
  logic [31:0] pc_F [1:0];
  logic [31:0] instr_F [1:0];
  logic [31:0] normal_F [1:0];
  logic        push_ready;
  logic [1:0]  valid_De;
  logic [31:0] pc_De [1:0];
  logic [31:0] instr_De [1:0];
  logic [31:0] normal_De [1:0];
  logic [3:0]  count;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] normal;
  } entry_t;

  entry_t model[$];
  bit     modelOvf = 1'b0;

  typedef struct {
    logic        fl;
    logic [1:0]  pv;
    logic [1:0]  pop;
    logic [31:0] pc0, pc1, in0, in1;
    int          eCnt;
    logic [1:0]  eVal;
    logic [31:0] ePc0, ePc1;
    logic        eRdy, eOvf;
  } vec_t;

  vec_t vecs[$];

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_valid_F(push_valid_F),
    .pc_F(pc_F), .instr_F(instr_F), .normal_F(normal_F), .push_ready(push_ready),
    .pop_count(pop_count), .valid_De(valid_De), .pc_De(pc_De), .instr_De(instr_De),
    .normal_De(normal_De), .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: a queue of entries; readiness judged on occupancy before any pop.
  task automatic modelStep(input logic fl, input logic [1:0] pv, input logic [1:0] pop);
    int eff;
    bit ready;
    entry_t e;
    if (fl) begin
      model.delete();
      return;
    end
    ready = (model.size() <= DEPTH - 2);
    eff = (pop == 2'd0) ? 0 : (pop == 2'd1) ? 1 : 2;
    if (eff > model.size()) eff = model.size();
    repeat (eff) void'(model.pop_front());
    if (pv != 2'b00) begin
      if (ready) begin
        for (int l = 0; l < 2; l++) begin
          if (pv[l]) begin
            e.pc = pc_F[l]; e.instr = instr_F[l]; e.normal = normal_F[l];
            model.push_back(e);
          end
        end
      end else begin
        modelOvf = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic [1:0] pv, input logic [1:0] pop,
                               input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic [31:0] in0, input logic [31:0] in1);
    flush = fl; push_valid_F = pv; pop_count = pop;
    pc_F[0] = pc0; pc_F[1] = pc1;
    instr_F[0] = in0; instr_F[1] = in1;
    normal_F[0] = pc0 + 32'd4; normal_F[1] = pc1 + 32'd4;
    modelStep(fl, pv, pop);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    entry_t e;
    check({tag, " count"}, 32'(count), 32'(model.size()));
    check({tag, " valid_De"}, 32'(valid_De),
          32'({model.size() >= 2, model.size() >= 1}));
    check({tag, " push_ready"}, 32'(push_ready), 32'(model.size() <= DEPTH - 2));
    check({tag, " overflow_err"}, 32'(overflow_err), 32'(modelOvf));
    for (int l = 0; l < 2; l++) begin
      e = '{32'h0, 32'h0, 32'h0};
      if (model.size() > l) e = model[l];
      check($sformatf("%s pc_De%0d", tag, l), pc_De[l], e.pc);
      check($sformatf("%s instr_De%0d", tag, l), instr_De[l], e.instr);
      check($sformatf("%s normal_De%0d", tag, l), normal_De[l], e.normal);
    end
  endtask

  task automatic resetDut();
    flush = 1'b0; push_valid_F = 2'b00; pop_count = 2'b00;
    rst = 1'b0;
    model.delete();
    modelOvf = 1'b0;
    #2;
    checkOutput("reset");
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      pc_F[l] = '0; instr_F[l] = '0; normal_F[l] = '0;
    end
    #1;
    rst = 1'b0;
    #2;
    checkOutput("power-on reset");
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // fl pv pop pc0 pc1 in0 in1 | count valid pcDe0 pcDe1 ready ovf
    vecs.push_back(vec_t'{0, 2'b11, 2'd0, 32'h00, 32'h04, 32'h00100093, 32'h00208093, 2, 2'b11, 32'h00, 32'h04, 1, 0});
    vecs.push_back(vec_t'{0, 2'b11, 2'd0, 32'h08, 32'h0C, 32'h11, 32'h12, 4, 2'b11, 32'h00, 32'h04, 1, 0});
    vecs.push_back(vec_t'{0, 2'b11, 2'd0, 32'h10, 32'h14, 32'h13, 32'h14, 6, 2'b11, 32'h00, 32'h04, 1, 0});
    vecs.push_back(vec_t'{0, 2'b11, 2'd0, 32'h18, 32'h1C, 32'h15, 32'h16, 8, 2'b11, 32'h00, 32'h04, 0, 0});
    vecs.push_back(vec_t'{0, 2'b11, 2'd0, 32'h20, 32'h24, 32'h17, 32'h18, 8, 2'b11, 32'h00, 32'h04, 0, 1});
    vecs.push_back(vec_t'{0, 2'b00, 2'd2, 32'h00, 32'h00, 32'h00, 32'h00, 6, 2'b11, 32'h08, 32'h0C, 1, 1});
    vecs.push_back(vec_t'{0, 2'b00, 2'd2, 32'h00, 32'h00, 32'h00, 32'h00, 4, 2'b11, 32'h10, 32'h14, 1, 1});
    vecs.push_back(vec_t'{0, 2'b00, 2'd2, 32'h00, 32'h00, 32'h00, 32'h00, 2, 2'b11, 32'h18, 32'h1C, 1, 1});
    vecs.push_back(vec_t'{0, 2'b11, 2'd0, 32'h28, 32'h2C, 32'h19, 32'h1A, 4, 2'b11, 32'h18, 32'h1C, 1, 1});
    vecs.push_back(vec_t'{0, 2'b11, 2'd0, 32'h30, 32'h34, 32'h1B, 32'h1C, 6, 2'b11, 32'h18, 32'h1C, 1, 1});
    vecs.push_back(vec_t'{0, 2'b11, 2'd2, 32'h38, 32'h3C, 32'h1D, 32'h1E, 6, 2'b11, 32'h28, 32'h2C, 1, 1});
    vecs.push_back(vec_t'{0, 2'b00, 2'd2, 32'h00, 32'h00, 32'h00, 32'h00, 4, 2'b11, 32'h30, 32'h34, 1, 1});
    vecs.push_back(vec_t'{0, 2'b00, 2'd2, 32'h00, 32'h00, 32'h00, 32'h00, 2, 2'b11, 32'h38, 32'h3C, 1, 1});
    vecs.push_back(vec_t'{0, 2'b00, 2'd1, 32'h00, 32'h00, 32'h00, 32'h00, 1, 2'b01, 32'h3C, 32'h00, 1, 1});
    vecs.push_back(vec_t'{0, 2'b00, 2'd2, 32'h00, 32'h00, 32'h00, 32'h00, 0, 2'b00, 32'h00, 32'h00, 1, 1});
    vecs.push_back(vec_t'{0, 2'b01, 2'd0, 32'h40, 32'h00, 32'h21, 32'h00, 1, 2'b01, 32'h40, 32'h00, 1, 1});
    vecs.push_back(vec_t'{0, 2'b11, 2'd3, 32'h44, 32'h48, 32'h22, 32'h23, 2, 2'b11, 32'h44, 32'h48, 1, 1});
    vecs.push_back(vec_t'{0, 2'b11, 2'd0, 32'h4C, 32'h50, 32'h24, 32'h25, 4, 2'b11, 32'h44, 32'h48, 1, 1});
    vecs.push_back(vec_t'{0, 2'b01, 2'd0, 32'h54, 32'h00, 32'h26, 32'h00, 5, 2'b11, 32'h44, 32'h48, 1, 1});
    vecs.push_back(vec_t'{1, 2'b11, 2'd2, 32'h60, 32'h64, 32'h27, 32'h28, 0, 2'b00, 32'h00, 32'h00, 1, 1});
    vecs.push_back(vec_t'{0, 2'b01, 2'd0, 32'h50, 32'h54, 32'h29, 32'h2A, 1, 2'b01, 32'h50, 32'h00, 1, 1});
    vecs.push_back(vec_t'{1, 2'b00, 2'd0, 32'h00, 32'h00, 32'h00, 32'h00, 0, 2'b00, 32'h00, 32'h00, 1, 1});
    vecs.push_back(vec_t'{0, 2'b10, 2'd0, 32'hDEAD, 32'h104, 32'h2B, 32'h2C, 1, 2'b01, 32'h104, 32'h00, 1, 1});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].fl, vecs[i].pv, vecs[i].pop, vecs[i].pc0, vecs[i].pc1,
                    vecs[i].in0, vecs[i].in1);
      check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].eCnt));
      check($sformatf("vec%0d valid_De", i), 32'(valid_De), 32'(vecs[i].eVal));
      check($sformatf("vec%0d pc_De0", i), pc_De[0], vecs[i].ePc0);
      check($sformatf("vec%0d pc_De1", i), pc_De[1], vecs[i].ePc1);
      check($sformatf("vec%0d push_ready", i), 32'(push_ready), 32'(vecs[i].eRdy));
      check($sformatf("vec%0d overflow_err", i), 32'(overflow_err), 32'(vecs[i].eOvf));
      checkOutput($sformatf("vec%0d model", i));
    end

    // Reset dropped mid-cycle must clear everything before the next clock edge.
    push_valid_F = 2'b00; pop_count = 2'b00; flush = 1'b0;
    #2;
    rst = 1'b0;
    model.delete();
    modelOvf = 1'b0;
    #1;
    check("async reset count", 32'(count), 32'h0);
    check("async reset overflow_err", 32'(overflow_err), 32'h0);
    checkOutput("async reset");
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Flush while full-ish must discard the push without flagging overflow.
    applyStimulus(0, 2'b11, 2'd0, 32'h100, 32'h104, 32'h1, 32'h2);
    applyStimulus(0, 2'b11, 2'd0, 32'h108, 32'h10C, 32'h3, 32'h4);
    applyStimulus(0, 2'b11, 2'd0, 32'h110, 32'h114, 32'h5, 32'h6);
    applyStimulus(0, 2'b01, 2'd0, 32'h118, 32'h0, 32'h7, 32'h0);
    check("count7 push_ready", 32'(push_ready), 32'h0);
    checkOutput("count7");
    applyStimulus(1, 2'b11, 2'd0, 32'h200, 32'h204, 32'h8, 32'h9);
    check("flush no overflow", 32'(overflow_err), 32'h0);
    check("flush count", 32'(count), 32'h0);
    checkOutput("flush");

    // count=7 with pop 2 still refuses the push.
    applyStimulus(0, 2'b11, 2'd0, 32'h300, 32'h304, 32'hA, 32'hB);
    applyStimulus(0, 2'b11, 2'd0, 32'h308, 32'h30C, 32'hC, 32'hD);
    applyStimulus(0, 2'b11, 2'd0, 32'h310, 32'h314, 32'hE, 32'hF);
    applyStimulus(0, 2'b01, 2'd0, 32'h318, 32'h0, 32'h10, 32'h0);
    applyStimulus(0, 2'b11, 2'd2, 32'h320, 32'h324, 32'h11, 32'h12);
    check("full pop count", 32'(count), 32'h5);
    check("full pop overflow", 32'(overflow_err), 32'h1);
    check("full pop head pc", pc_De[0], 32'h308);
    checkOutput("full pop");

    resetDut();
    for (int i = 0; i < 800; i++) begin
      logic       fl;
      logic [1:0] pv, pop;
      fl  = ($urandom_range(0, 31) == 0);
      pv  = 2'($urandom_range(0, 3));
      pop = (i < 400) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      applyStimulus(fl, pv, pop, $urandom, $urandom, $urandom, $urandom);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Dual-lane instruction FIFO between the fetch stage and the decode pipeline register. It decouples instruction-memory fetch from decode/issue back-pressure. Each cycle it accepts up to two fetched instructions with their PC and PC+4, and it presents the two oldest entries to decode. It is emptied on a branch/jump redirect flush.

## Interface
Parameters:
- WIDTH, 32, data/PC width.
- DEPTH, 8, number of entries; a power of two, at least 4.
- PTR_W, log2(DEPTH), derived pointer width; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately when low.
- flush  in  1  redirect; empties the queue at the next edge.
- push_valid_F  in  2  per-lane fetch valid.
- pc_F[1:0]  in  WIDTH each  lane PCs.
- instr_F[1:0]  in  WIDTH each  lane instruction words.
- normal_F[1:0]  in  WIDTH each  lane PC+4 values.
- push_ready  out  1  high when free slots ≥ 2.
- pop_count  in  2  entries consumed by decode this cycle; legal values 0, 1, 2.
- valid_De  out  2  bit0 = count≥1; bit1 = count≥2.
- pc_De[1:0], instr_De[1:0], normal_De[1:0]  out  WIDTH each  lane0 = head entry, lane1 = head+1 entry.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.
- overflow_err  out  1  sticky; set when a push is dropped.

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry holds {pc, instr, normal}.
- Pointers: head_ptr (read) and tail_ptr (write), each PTR_W bits, wrapping modulo DEPTH. count is a separate register.
- Push:
  - Valid lanes are enqueued compacted, in lane order (lane0 first).
  - push_valid_F=2'b11 writes lane0 at tail and lane1 at tail+1, then tail += 2.
  - 2'b01 writes lane0 at tail; 2'b10 writes lane1 at tail; either way tail += 1.
  - 2'b00 writes nothing.
- Push acceptance:
  - Any push is accepted only if push_ready=1. push_ready is computed from the registered count before this cycle's pop. There is no pop-to-push bypass.
  - A push while push_ready=0 is dropped entirely (neither lane is written) and sets overflow_err.
- Pop:
  - pop_eff = min(pop_count, count); head += pop_eff.
  - pop_count=3 is treated as 2.
  - Popping an empty queue has no effect and is not an error.
- Occupancy: count_next = count + pushes_accepted − pop_eff.
- Flush:
  - Has priority over push and pop in the same cycle.
  - Sets head=tail=0 and count=0.
  - Push data presented in the flush cycle is discarded; it does not set overflow_err.
- Outputs:
  - Combinational reads of storage at head and head+1 (modulo DEPTH).
  - Any lane with valid_De bit = 0 drives all-zero pc/instr/normal.
- overflow_err clears only on reset.

## Timing
- Reset (rst low, asynchronous): count=0, head=tail=0, overflow_err=0, valid_De=2'b00, all De data outputs 0, push_ready=1. Storage contents are don't-care but are never visible, because outputs are masked.
- Push-to-output latency is 1 cycle. An entry written at edge N appears on the De outputs after edge N, provided it is at head or head+1.
- A pop takes effect at the edge. The next entries appear after that edge.
- Simultaneous push and pop: both apply at the same edge. Ordering is preserved: popped entries are always older than pushed entries.
- Full boundary:
  - count=DEPTH−1 or DEPTH gives push_ready=0, even if pop_count=2 in that cycle.
  - count=DEPTH−2 gives push_ready=1.
- Wrap-around: tail=DEPTH−1 with a 2-lane push writes entry DEPTH−1 and entry 0, and tail becomes 1. Head reads wrap the same way.
- rst asserted mid-operation: all state clears immediately, regardless of clk.

## Test plan
- Reset, then push 2'b11 with pc={0x04,0x00}, instr={0x00208093,0x00100093}, normal={0x08,0x04} → next cycle count=2, valid_De=2'b11, pc_De[0]=0x00, pc_De[1]=0x04, normal_De[0]=0x04.
- Push 2'b11 for 4 consecutive cycles with pop_count=0 at DEPTH=8 → count=8, push_ready=0. A fifth push of 2'b11 → count stays 8 and overflow_err=1.
- count=6 (head=6, tail=4 after wrap), push 2'b11 with pop_count=2 in the same cycle → count=6, head=0, and the new entries land at indices 4 and 5.
- count=1, pop_count=2 with no push → count=0, valid_De=2'b00, all De data=0, head advanced by 1.
- count=5, flush=1 with push 2'b11 and pop_count=2 in the same cycle → count=0, valid_De=2'b00, overflow_err unchanged. A push of 2'b01 on the next cycle → count=1 and pc_De[0] equals the pushed lane0 PC.
- push_valid_F=2'b10 with pc_F[1]=0x104 into an empty queue → count=1, valid_De=2'b01, pc_De[0]=0x104. Then assert rst low mid-cycle → all outputs 0 before the next edge.
